// File: rtl/data_mem_lw_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_lw_if
//  Description : Core-side load request and data-memory read handshake
//                bundle for data_mem_lw.
//                master : core + memory model (drives requests, acks, data)
//                slave  : load unit (drives mem_req/mem_addr, load results)
//  Signals     : load_req, lw_sw_op[2:0], addr[31:0]      core -> unit
//                mem_req, mem_addr[31:0]                   unit -> memory
//                mem_ack, mem_rdata[31:0]                  memory -> unit
//                load_data[31:0], load_valid, load_fault,
//                load_stall                                unit -> core
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_lw_if;
    logic        load_req;
    logic [2:0]  lw_sw_op;
    logic [31:0] addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_fault;
    logic        load_stall;

    modport master (
        output load_req, lw_sw_op, addr, mem_ack, mem_rdata,
        input  mem_req, mem_addr, load_data, load_valid, load_fault, load_stall
    );

    modport slave (
        input  load_req, lw_sw_op, addr, mem_ack, mem_rdata,
        output mem_req, mem_addr, load_data, load_valid, load_fault, load_stall
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_lw.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_lw
//  Description : Load-side memory access unit. Accepts a load from the core,
//                issues a word-aligned read over a req/ack handshake, then
//                extracts and sign/zero-extends the addressed byte, halfword
//                or word. Stalls the core while the read is outstanding and
//                reports misaligned, illegal-op and timed-out loads as faults.
//  Ports       : clk            system clock, rising edge
//                rst_n          asynchronous active-low reset
//                bus (slave)    load request / memory handshake / results
//  Parameters  : TIMEOUT_CYCLES max WAIT cycles without ack (0..255, 0=off)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_lw #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    data_mem_lw_if.slave bus
);
    localparam logic [2:0] c_op_lb  = 3'b000;
    localparam logic [2:0] c_op_lh  = 3'b001;
    localparam logic [2:0] c_op_lw  = 3'b010;
    localparam logic [2:0] c_op_lbu = 3'b100;
    localparam logic [2:0] c_op_lhu = 3'b101;

    localparam logic       c_tmo_en   = (TIMEOUT_CYCLES != 0);
    // Last counter value before expiry; wraps harmlessly when disabled.
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [31:0] r_mem_addr;
    logic [31:0] r_load_data;
    logic [7:0]  r_cnt;
    logic        r_mem_req;
    logic        r_load_valid;
    logic        r_load_fault;

    logic        w_op_legal;
    logic        w_misaligned;
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // Request qualification, evaluated on the live request in IDLE.
    always_comb begin
        w_op_legal = 1'b0;
        case (bus.lw_sw_op)
            c_op_lb, c_op_lh, c_op_lw, c_op_lbu, c_op_lhu: w_op_legal = 1'b1;
            default:                                       w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        if ((bus.lw_sw_op == c_op_lh || bus.lw_sw_op == c_op_lhu) && bus.addr[0])
            w_misaligned = 1'b1;
        if (bus.lw_sw_op == c_op_lw && bus.addr[1:0] != 2'b00)
            w_misaligned = 1'b1;
    end

    // Lane extraction uses the captured op/lane, so the core may change
    // its request inputs freely while the read is outstanding.
    always_comb begin
        w_shift = bus.mem_rdata >> {r_lane, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_op)
            c_op_lb:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: w_ext = {24'h000000, w_byte};
            c_op_lh:  w_ext = {{16{w_half[15]}}, w_half};
            c_op_lhu: w_ext = {16'h0000, w_half};
            default:  w_ext = bus.mem_rdata;
        endcase
    end

    // Handshake outputs are flops set together with the next state so they
    // never glitch and drop asynchronously with reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= 3'b000;
            r_lane       <= 2'b00;
            r_mem_addr   <= 32'h0;
            r_load_data  <= 32'h0;
            r_cnt        <= 8'h00;
            r_mem_req    <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_fault <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            r_load_fault <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.load_req) begin
                        r_op       <= bus.lw_sw_op;
                        r_lane     <= bus.addr[1:0];
                        r_mem_addr <= {bus.addr[31:2], 2'b00};
                        r_cnt      <= 8'h00;
                        if (!w_op_legal || w_misaligned) begin
                            r_state      <= S_FAULT;
                            r_load_fault <= 1'b1;
                        end else begin
                            r_state   <= S_WAIT;
                            r_mem_req <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // Ack is checked first so it wins over a coincident expiry.
                    if (bus.mem_ack) begin
                        r_load_data  <= w_ext;
                        r_state      <= S_DONE;
                        r_mem_req    <= 1'b0;
                        r_load_valid <= 1'b1;
                    end else if (c_tmo_en && r_cnt == c_tmo_last) begin
                        r_state      <= S_FAULT;
                        r_mem_req    <= 1'b0;
                        r_load_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.load_data  = r_load_data;
    assign bus.load_valid = r_load_valid;
    assign bus.load_fault = r_load_fault;
    // Combinational from load_req so the core stalls in the acceptance cycle.
    assign bus.load_stall = (r_state == S_IDLE && bus.load_req) || (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lw.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_lw
//  Description : Self-checking bench for data_mem_lw (TIMEOUT_CYCLES=4).
//                Table of load vectors driven cycle by cycle; expected
//                responses queued at issue and matched by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_lw;
    localparam int c_tmo = 4;

    localparam int K_OK  = 0;   // completes with ack
    localparam int K_BAD = 1;   // illegal op or misaligned, no memory request
    localparam int K_TMO = 2;   // request issued, never acked

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          ack;       // WAIT cycle index (>=1) carrying the ack
        int          kind;
        logic [31:0] data;      // expected load_data for K_OK
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    logic [31:0] last_data;
    exp_t sb[$];
    vec_t vecs[17];

    data_mem_lw_if bus();

    data_mem_lw #(.TIMEOUT_CYCLES(c_tmo)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every load_valid/load_fault pulse must match the
    // oldest outstanding expectation in kind, cycle and data.
    always @(negedge clk) begin
        if (bus.load_valid === 1'b1 || bus.load_fault === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'h0, bus.load_valid, bus.load_fault}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_kind", {30'h0, bus.load_valid, bus.load_fault},
                    e.fault ? 32'h1 : 32'h2);
                chk("resp_cycle", cyc, e.due);
                chk("load_data", bus.load_data, e.data);
            end
        end
    end

    task automatic check_drained();
        chk("pending_responses", sb.size(), 32'h0);
        if (sb.size() != 0) sb.delete();
    endtask

    // Drives one load starting in the current IDLE cycle (cycle 0) and
    // checks the per-cycle handshake until its response cycle.
    task automatic do_load(input vec_t v);
        int   lat;
        bit   waits;
        exp_t e;
        @(posedge clk); #1;
        check_drained();
        bus.load_req  = 1'b1;
        bus.lw_sw_op  = v.op;
        bus.addr      = v.addr;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom;
        waits = (v.kind != K_BAD);
        lat   = (v.kind == K_OK) ? v.ack + 1 : (v.kind == K_TMO) ? c_tmo + 1 : 1;
        e.fault = (v.kind != K_OK);
        e.data  = (v.kind == K_OK) ? v.data : last_data;
        e.due   = cyc + lat;
        if (v.kind == K_OK) last_data = v.data;
        sb.push_back(e);
        @(negedge clk);
        chk("stall_accept", {31'h0, bus.load_stall}, 32'h1);
        chk("mem_req_accept", {31'h0, bus.mem_req}, 32'h0);
        for (int c = 1; c <= lat; c++) begin
            @(posedge clk); #1;
            // Core inputs wander while busy; they must be ignored.
            bus.load_req = 1'($urandom_range(0, 1));
            bus.lw_sw_op = 3'($urandom);
            bus.addr     = $urandom;
            if (v.kind == K_OK && c == v.ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = v.rdata;
            end else begin
                // Stray ack only in the DONE/FAULT cycle, where it must be ignored.
                bus.mem_ack   = (c == lat) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.mem_rdata = $urandom;
            end
            @(negedge clk);
            chk("mem_req", {31'h0, bus.mem_req}, {31'h0, (waits && c < lat)});
            chk("load_stall", {31'h0, bus.load_stall}, {31'h0, (waits && c < lat)});
            if (waits && c < lat)
                chk("mem_addr", bus.mem_addr, v.addr & 32'hFFFF_FFFC);
        end
        @(posedge clk); #1;
        bus.load_req = 1'b0;
        bus.mem_ack  = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 1, K_OK,  32'hDEAD_BEEF};
        vecs[1]  = '{3'b000, 32'h0000_2000, 32'h80FF_7F01, 1, K_OK,  32'h0000_0001};
        vecs[2]  = '{3'b000, 32'h0000_2001, 32'h80FF_7F01, 2, K_OK,  32'h0000_007F};
        vecs[3]  = '{3'b000, 32'h0000_2002, 32'h80FF_7F01, 3, K_OK,  32'hFFFF_FFFF};
        vecs[4]  = '{3'b000, 32'h0000_2003, 32'h80FF_7F01, 1, K_OK,  32'hFFFF_FF80};
        vecs[5]  = '{3'b100, 32'h0000_2003, 32'h80FF_7F01, 1, K_OK,  32'h0000_0080};
        vecs[6]  = '{3'b010, 32'h0000_1002, 32'h0,         0, K_BAD, 32'h0};
        vecs[7]  = '{3'b001, 32'h0000_0002, 32'h8001_F00F, 2, K_OK,  32'hFFFF_8001};
        vecs[8]  = '{3'b101, 32'h0000_0002, 32'h8001_F00F, 1, K_OK,  32'h0000_8001};
        vecs[9]  = '{3'b001, 32'h0000_0000, 32'h8001_F00F, 1, K_OK,  32'hFFFF_F00F};
        vecs[10] = '{3'b001, 32'h0000_0001, 32'h0,         0, K_BAD, 32'h0};
        vecs[11] = '{3'b011, 32'h0000_1000, 32'h0,         0, K_BAD, 32'h0};
        vecs[12] = '{3'b101, 32'h0000_0000, 32'h8001_F00F, 2, K_OK,  32'h0000_F00F};
        vecs[13] = '{3'b010, 32'h0000_3000, 32'h0,         0, K_TMO, 32'h0};
        vecs[14] = '{3'b010, 32'h0000_3004, 32'h1234_5678, 4, K_OK,  32'h1234_5678};
        vecs[15] = '{3'b111, 32'h0000_3008, 32'h0,         0, K_BAD, 32'h0};
        vecs[16] = '{3'b100, 32'hFFFF_FFFD, 32'h80FF_7F01, 1, K_OK,  32'h0000_007F};

        n_chk = 0;
        n_fail = 0;
        last_data = 32'h0;
        rst_n = 1'b0;
        bus.load_req  = 1'b0;
        bus.lw_sw_op  = 3'b000;
        bus.addr      = 32'h0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("rst_load_valid", {31'h0, bus.load_valid}, 32'h0);
        chk("rst_load_fault", {31'h0, bus.load_fault}, 32'h0);
        chk("rst_load_stall", {31'h0, bus.load_stall}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_load_data", bus.load_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) do_load(vecs[i]);

        // Reset while a read is outstanding, then a stray ack after release.
        @(posedge clk); #1;
        check_drained();
        bus.load_req = 1'b1;
        bus.lw_sw_op = 3'b010;
        bus.addr     = 32'h0000_4000;
        @(posedge clk); #1;
        bus.load_req = 1'b0;
        @(negedge clk);
        chk("mid_wait_mem_req", {31'h0, bus.mem_req}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        chk("async_rst_valid", {31'h0, bus.load_valid}, 32'h0);
        chk("async_rst_fault", {31'h0, bus.load_fault}, 32'h0);
        chk("async_rst_stall", {31'h0, bus.load_stall}, 32'h0);
        chk("async_rst_mem_addr", bus.mem_addr, 32'h0);
        chk("async_rst_load_data", bus.load_data, 32'h0);
        last_data = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stray_ack_valid", {31'h0, bus.load_valid}, 32'h0);
            chk("stray_ack_mem_req", {31'h0, bus.mem_req}, 32'h0);
            chk("stray_ack_load_data", bus.load_data, 32'h0);
        end

        do_load(vecs[0]);
        @(posedge clk); #1;
        check_drained();
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
